// File: rtl/baby_store_loader.sv
// Main store for the Manchester Baby core: 32 x 32-bit memory on the core's RAM bus,
// plus a byte-stream loader that fills the store while holding the core in reset.
module baby_store_loader #(
    parameter int LOAD_WORDS = 32
) (
    input  logic        clock,
    input  logic        reset_i,
    input  logic [4:0]  ram_addr_i,
    input  logic        ram_rw_en_i,
    inout  wire  [31:0] ram_data_io,
    input  logic        load_start_i,
    input  logic [7:0]  load_data_i,
    input  logic        load_valid_i,
    output logic        load_ready_o,
    output logic        cpu_reset_o,
    output logic        loaded_o
);

    // state     | meaning
    // S_IDLE    | no session; core held in reset, loader not ready
    // S_COLLECT | accepting bytes 0..3 of the current word (little-endian)
    // S_WRITE   | one cycle: assembled word written to the store
    // S_RUN     | image loaded; core released and owns the RAM bus
    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_RUN
    } state_t;

    localparam logic [4:0] LAST_ADDR = 5'(LOAD_WORDS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_cnt;
    logic [1:0]  w_next_cnt;
    logic [4:0]  r_waddr;
    logic [4:0]  w_next_waddr;
    logic [31:0] r_asm;
    logic [31:0] w_next_asm;
    logic [31:0] r_store [32];
    logic        w_core_rd;
    logic        w_core_wr;

    always_ff @(posedge clock) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_waddr <= '0;
            r_asm   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_waddr <= w_next_waddr;
            r_asm   <= w_next_asm;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_waddr = r_waddr;
        w_next_asm   = r_asm;
        load_ready_o = 1'b0;
        cpu_reset_o  = 1'b1;
        loaded_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
            end
            S_COLLECT: begin
                // a start pulse wins over a byte, so the handshake is withheld
                load_ready_o = !load_start_i;
                if (load_valid_i && !load_start_i) begin
                    w_next_asm[{r_cnt, 3'b000} +: 8] = load_data_i;
                    w_next_cnt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_next_state = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (r_waddr == LAST_ADDR) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_waddr = r_waddr + 5'd1;
                    w_next_cnt   = 2'd0;
                    w_next_state = S_COLLECT;
                end
            end
            S_RUN: begin
                cpu_reset_o = 1'b0;
                loaded_o    = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (load_start_i) begin
            w_next_state = S_COLLECT;
            w_next_cnt   = 2'd0;
            w_next_waddr = 5'd0;
        end
    end

    assign w_core_rd = (r_state == S_RUN) && !ram_rw_en_i;
    assign w_core_wr = (r_state == S_RUN) && ram_rw_en_i;

    assign ram_data_io = w_core_rd ? r_store[ram_addr_i] : 'z;

    // store contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (!reset_i) begin
            if (r_state == S_WRITE) begin
                r_store[r_waddr] <= r_asm;
            end else if (w_core_wr) begin
                r_store[ram_addr_i] <= ram_data_io;
            end
        end
    end

endmodule
